// File: rtl/ex_mem_reg.sv
// Execute-to-memory pipeline boundary: owns the {ZF,SF,OF} condition codes,
// evaluates jump/cmov conditions, and latches the M-stage register.
module ex_mem_reg #(
    parameter int         W     = 32,
    parameter logic [3:0] RNONE = 4'hF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall_i,
    input  logic         bubble_i,
    input  logic         set_cc_i,
    input  logic [3:0]   icode_i,
    input  logic [3:0]   ifun_i,
    input  logic [W-1:0] valA_i,
    input  logic [W-1:0] valB_i,
    input  logic [W-1:0] valE_i,
    input  logic [3:0]   dstE_i,
    input  logic [3:0]   dstM_i,
    output logic [2:0]   cc_o,
    output logic         e_cnd_o,
    output logic [3:0]   m_icode_o,
    output logic         m_cnd_o,
    output logic [W-1:0] m_valE_o,
    output logic [W-1:0] m_valA_o,
    output logic [3:0]   m_dstE_o,
    output logic [3:0]   m_dstM_o,
    output logic         m_valid_o
);

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVL = 4'h2;
    localparam logic [3:0] I_OPL    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;

    localparam logic [3:0] F_ADDL = 4'h0;
    localparam logic [3:0] F_SUBL = 4'h1;
    localparam logic [3:0] F_XORL = 4'h3;

    logic       zf, sf, of;
    logic       cond;
    logic       cc_we;
    logic       sa, sb, se;
    logic       new_of;
    logic [3:0] dstE_sq;

    assign {zf, sf, of} = cc_o;

    always_comb begin
        cond = 1'b0;
        case (ifun_i)
            4'h0:    cond = 1'b1;
            4'h1:    cond = (sf ^ of) | zf;
            4'h2:    cond = sf ^ of;
            4'h3:    cond = zf;
            4'h4:    cond = ~zf;
            4'h5:    cond = ~(sf ^ of);
            4'h6:    cond = ~(sf ^ of) & ~zf;
            default: cond = 1'b0;
        endcase
    end

    assign e_cnd_o = ((icode_i == I_JXX) || (icode_i == I_RRMOVL)) ? cond : 1'b0;

    // A cmov whose condition fails must not write its destination.
    assign dstE_sq = ((icode_i == I_RRMOVL) && !e_cnd_o) ? RNONE : dstE_i;

    assign sa = valA_i[W-1];
    assign sb = valB_i[W-1];
    assign se = valE_i[W-1];

    always_comb begin
        new_of = 1'b0;
        if (ifun_i == F_ADDL)
            new_of = (sa == sb) && (se != sa);
        else if (ifun_i == F_SUBL)
            new_of = (sa != sb) && (se != sb);
    end

    // Flags update only for the four ALU ops; unknown OPL ifuns leave CC alone.
    assign cc_we = (icode_i == I_OPL) && (ifun_i <= F_XORL) && set_cc_i && !stall_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            cc_o      <= 3'b100;
            m_icode_o <= I_NOP;
            m_cnd_o   <= 1'b0;
            m_valE_o  <= '0;
            m_valA_o  <= '0;
            m_dstE_o  <= RNONE;
            m_dstM_o  <= RNONE;
            m_valid_o <= 1'b0;
        end else if (!stall_i) begin
            if (cc_we)
                cc_o <= {(valE_i == '0), se, new_of};
            if (bubble_i) begin
                m_icode_o <= I_NOP;
                m_cnd_o   <= 1'b0;
                m_valE_o  <= '0;
                m_valA_o  <= '0;
                m_dstE_o  <= RNONE;
                m_dstM_o  <= RNONE;
                m_valid_o <= 1'b0;
            end else begin
                m_icode_o <= icode_i;
                m_cnd_o   <= e_cnd_o;
                m_valE_o  <= valE_i;
                m_valA_o  <= valA_i;
                m_dstE_o  <= dstE_sq;
                m_dstM_o  <= dstM_i;
                m_valid_o <= 1'b1;
            end
        end
    end

endmodule
